// File: rtl/wb_keypad4x4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_keypad4x4 : Wishbone 4x4 key-matrix scanner, debounced bitmap + FIFO  |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module wb_keypad4x4 #(
  parameter int WB_CLK_HZ  = 48_000_000,
  parameter int SCAN_HZ    = 1_000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic [3:0]  keypad_col_o,
  output logic [3:0]  keypad_col_oe,
  input  logic [3:0]  keypad_row_i
);

  localparam int c_SLOT  = WB_CLK_HZ / SCAN_HZ;
  localparam int c_DIV_W = $clog2(c_SLOT);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  // SAMPLE lands on divider SLOT-6 so SAMPLE, four COMMITs and NEXT close the slot at SLOT-1.
  localparam logic [c_DIV_W-1:0] c_SETTLE_LAST = c_DIV_W'(c_SLOT - 7);
  localparam logic [c_DIV_W-1:0] c_SLOT_LAST   = c_DIV_W'(c_SLOT - 1);
  localparam logic [c_CNT_W-1:0] c_FULL        = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_SETTLE = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_COMMIT = 3'd2,
    ST_NEXT   = 3'd3
  } state_t;

  state_t               r_state;
  logic [c_DIV_W-1:0]   r_div;
  logic [1:0]           r_col;
  logic [3:0]           r_oe;
  logic [1:0]           r_row;
  logic [15:0]          r_bitmap;
  logic [DEBOUNCE-1:0]  r_hist [16];
  logic [3:0]           r_row_meta;
  logic [3:0]           r_row_sync;

  logic [4:0]           r_fifo_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_overflow;
  logic                 r_ack;
  logic [31:0]          r_dat;

  logic [3:0]           w_pressed;
  logic [3:0]           w_key;
  logic [DEBOUNCE-1:0]  w_hist_k;
  logic                 w_all_one;
  logic                 w_all_zero;
  logic                 w_push;
  logic [4:0]           w_event;
  logic                 w_req;
  logic                 w_rd;
  logic                 w_wr;
  logic                 w_pop;
  logic                 w_flush;
  logic                 w_ovf_clr;
  logic                 w_full;
  logic                 w_do_push;
  logic                 w_drop;
  logic [31:0]          w_rdata;
  logic                 w_unused_dat;

  assign keypad_col_o  = 4'b0000;
  assign keypad_col_oe = r_oe;
  assign wb_stall_o    = 1'b0;
  assign wb_ack_o      = r_ack;
  assign wb_dat_o      = r_dat;
  assign w_unused_dat  = ^wb_dat_i[31:1];

  assign w_pressed  = ~r_row_sync;
  assign w_key      = {r_row, r_col};
  assign w_hist_k   = r_hist[w_key];
  assign w_all_one  = &w_hist_k;
  assign w_all_zero = ~|w_hist_k;
  assign w_push     = (r_state == ST_COMMIT) &&
                      ((w_all_one && !r_bitmap[w_key]) || (w_all_zero && r_bitmap[w_key]));
  assign w_event    = {w_all_zero, w_key};

  assign w_req     = wb_cyc_i & wb_stb_i;
  assign w_rd      = w_req & ~wb_we_i;
  assign w_wr      = w_req & wb_we_i;
  assign w_pop     = w_rd && (wb_adr_i == 4'd1) && (r_count != '0);
  assign w_flush   = w_wr && (wb_adr_i == 4'd3) && wb_dat_i[0];
  assign w_ovf_clr = w_rd && (wb_adr_i == 4'd2);
  assign w_full    = (r_count == c_FULL);
  assign w_do_push = w_push && (!w_full || w_pop) && !w_flush;
  assign w_drop    = w_push && w_full && !w_pop;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= keypad_row_i;
      r_row_sync <= r_row_meta;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= ST_SETTLE;
      r_div    <= '0;
      r_col    <= 2'd0;
      r_oe     <= 4'b0001;
      r_row    <= 2'd0;
      r_bitmap <= 16'h0000;
      for (int k = 0; k < 16; k++) r_hist[k] <= '0;
    end else begin
      r_div <= r_div + c_DIV_W'(1);
      case (r_state)
        ST_SETTLE: begin
          if (r_div == c_SETTLE_LAST) r_state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          for (int r = 0; r < 4; r++)
            r_hist[{2'(r), r_col}] <= {r_hist[{2'(r), r_col}][DEBOUNCE-2:0], w_pressed[r]};
          r_row   <= 2'd0;
          r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          if (w_push) r_bitmap[w_key] <= ~r_bitmap[w_key];
          if (r_row == 2'd3) r_state <= ST_NEXT;
          r_row <= r_row + 2'd1;
        end
        ST_NEXT: begin
          if (r_div == c_SLOT_LAST) begin
            r_div   <= '0;
            r_col   <= r_col + 2'd1;
            r_oe    <= {r_oe[2:0], r_oe[3]};
            r_state <= ST_SETTLE;
          end
        end
        default: r_state <= ST_SETTLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_do_push) r_fifo_mem[r_wr_ptr] <= w_event;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || w_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      if (w_do_push && !w_pop)      r_count <= r_count + c_CNT_W'(1);
      else if (!w_do_push && w_pop) r_count <= r_count - c_CNT_W'(1);
      // An overflow in the same cycle as the status read must survive the clear.
      if (w_drop)         r_overflow <= 1'b1;
      else if (w_ovf_clr) r_overflow <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = 32'h0;
    case (wb_adr_i)
      4'd0: w_rdata = {16'h0, r_bitmap};
      4'd1: if (r_count != '0) w_rdata = {23'h0, 1'b1, 3'b000, r_fifo_mem[r_rd_ptr]};
      4'd2: w_rdata = {23'h0, r_overflow, 8'(r_count)};
      default: w_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= 32'h0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : 32'h0;
    end
  end

endmodule
`default_nettype wire
